// File: rtl/sfifo_arb_pkg.sv
// Shared types and constants for the sfifo write-port arbiter.
// Pure declarations: no logic, no latency.
// Used by sfifo_wr_arbiter and its round-robin picker.
package sfifo_arb_pkg;

    // Two-state arbiter: choosing a source, or streaming the granted one
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of the packet counter exposed when statistics are built in
    localparam int PKT_CNT_W = 16;

    // Width of a grant index for nin requesters (never narrower than 1 bit)
    function automatic int rr_search_w(input int nin);
        return (nin <= 2) ? 1 : $clog2(nin);
    endfunction

endpackage

// File: rtl/sfifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or above i_start, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module rr_pick
    import sfifo_arb_pkg::*;
#(
    parameter int NIN   = 4,
    parameter int LGNIN = rr_search_w(NIN)
) (
    input  logic [NIN-1:0]   i_req,
    input  logic [LGNIN-1:0] i_start,
    output logic [LGNIN-1:0] o_idx,
    output logic             o_found
);

    logic             hi_found;
    logic [LGNIN-1:0] hi_idx;
    logic             lo_found;
    logic [LGNIN-1:0] lo_idx;

    // Wrap search without rotating: the lowest set bit at or above the start
    // wins; if none exists, the search has wrapped and the lowest set bit wins.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int k = NIN - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                lo_found = 1'b1;
                lo_idx   = LGNIN'(k);
                if (LGNIN'(k) >= i_start) begin
                    hi_found = 1'b1;
                    hi_idx   = LGNIN'(k);
                end
            end
        end
        o_found = lo_found;
        o_idx   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin arbiter sharing one sfifo write port among NIN valid/ready sources.
// Latency: 1 cycle to arbitrate (IDLE), then one beat per cycle while granted.
// Backpressure: i_full stalls the granted source (o_ready low, o_wr low); state held.
// Optional statistics (o_pkt_count, o_stall) built when SFIFO_WR_ARBITER_STATS_EN is defined.
module sfifo_wr_arbiter
    import sfifo_arb_pkg::*;
#(
    parameter int   NIN        = 4,
    parameter int   BW         = 8,
    parameter logic OPT_PACKET = 1'b1,
    parameter int   LGNIN      = rr_search_w(NIN)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NIN-1:0]    i_valid,
    input  logic [NIN*BW-1:0] i_data,
    input  logic [NIN-1:0]    i_last,
    output logic [NIN-1:0]    o_ready,
    output logic              o_wr,
    output logic [BW-1:0]     o_data,
    output logic              o_last,
    input  logic              i_full,
    output logic [NIN-1:0]    o_grant,
    output logic              o_busy
`ifdef SFIFO_WR_ARBITER_STATS_EN
    ,
    output logic [PKT_CNT_W-1:0] o_pkt_count,
    output logic                 o_stall
`endif
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [LGNIN-1:0] grant_q;
    logic [LGNIN-1:0] grant_d;
    logic [LGNIN-1:0] rr_q;
    logic [LGNIN-1:0] rr_d;
    logic [LGNIN-1:0] pick_idx;
    logic             pick_found;
    logic             locked;
    logic             cur_vld;
    logic             cur_last;
    logic [BW-1:0]    cur_dat;
    logic             pkt_end;

    rr_pick #(
        .NIN   (NIN),
        .LGNIN (LGNIN)
    ) u_pick (
        .i_req   (i_valid),
        .i_start (rr_q),
        .o_idx   (pick_idx),
        .o_found (pick_found)
    );

    assign locked = (state_q == LOCKED);

    // Select the granted source's beat and build the one-hot grant
    always_comb begin
        cur_vld  = 1'b0;
        cur_last = 1'b0;
        cur_dat  = '0;
        o_grant  = '0;
        for (int k = 0; k < NIN; k++) begin
            if (grant_q == LGNIN'(k)) begin
                cur_vld  = i_valid[k];
                cur_last = i_last[k];
                cur_dat  = i_data[k*BW +: BW];
                o_grant[k] = locked;
            end
        end
    end

    // Reset input gates the strobes so nothing reaches the FIFO during reset
    assign o_ready = (locked && i_reset_n && !i_full) ? o_grant : '0;
    assign o_wr    = locked && i_reset_n && cur_vld && !i_full;
    assign o_data  = cur_dat;
    assign o_last  = cur_last;
    assign o_busy  = locked;

    // A grant ends on an accepted last beat, or on every beat in beat mode
    assign pkt_end = o_wr && (cur_last || !OPT_PACKET);

    // Next state: pick in IDLE, release and advance the pointer at packet end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    grant_d = pick_idx;
                end
            end
            LOCKED: begin
                if (pkt_end) begin
                    state_d = IDLE;
                    rr_d    = (grant_q == LGNIN'(NIN - 1)) ? '0 : grant_q + LGNIN'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

`ifdef SFIFO_WR_ARBITER_STATS_EN
    logic [PKT_CNT_W-1:0] pkt_cnt_q;

    // Count completed packets (every beat in beat mode); wraps naturally
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pkt_cnt_q <= '0;
        end else if (pkt_end) begin
            pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
        end
    end

    assign o_pkt_count = pkt_cnt_q;
    assign o_stall     = locked && cur_vld && i_full;
`endif

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Bench for sfifo_wr_arbiter: dut 0 in packet mode, dut 1 in beat mode.
// Sources are queue-driven valid/ready models; a monitor scoreboards FIFO writes.
// Directed scenarios check grant timing, fairness, locking, backpressure, reset.
module tb_sfifo_wr_arbiter;

    localparam int NIN = 4;
    localparam int BW  = 8;

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] dat;
        logic       last;
    } exp_t;

    logic              clk;
    logic              rst_n [2];
    logic [NIN-1:0]    v_vld [2];
    logic [NIN*BW-1:0] v_dat [2];
    logic [NIN-1:0]    v_last[2];
    logic [NIN-1:0]    rdy   [2];
    logic              wr    [2];
    logic [BW-1:0]     odat  [2];
    logic              olast [2];
    logic              full  [2];
    logic [NIN-1:0]    grant [2];
    logic              busy  [2];
`ifdef SFIFO_WR_ARBITER_STATS_EN
    logic [15:0]       pcnt  [2];
    logic              stall [2];
`endif

    beat_t srcq[2][NIN][$];
    exp_t  sbq[2][$];
    logic [NIN-1:0] acc[2];
    exp_t  mon_e;
    int    wr_cnt[2];
    int    n_checks;
    int    n_pass;

    sfifo_wr_arbiter #(.NIN(NIN), .BW(BW), .OPT_PACKET(1'b1)) u_pkt (
        .i_clk(clk), .i_reset_n(rst_n[0]), .i_valid(v_vld[0]), .i_data(v_dat[0]),
        .i_last(v_last[0]), .o_ready(rdy[0]), .o_wr(wr[0]), .o_data(odat[0]),
        .o_last(olast[0]), .i_full(full[0]), .o_grant(grant[0]), .o_busy(busy[0])
`ifdef SFIFO_WR_ARBITER_STATS_EN
        , .o_pkt_count(pcnt[0]), .o_stall(stall[0])
`endif
    );

    sfifo_wr_arbiter #(.NIN(NIN), .BW(BW), .OPT_PACKET(1'b0)) u_beat (
        .i_clk(clk), .i_reset_n(rst_n[1]), .i_valid(v_vld[1]), .i_data(v_dat[1]),
        .i_last(v_last[1]), .o_ready(rdy[1]), .o_wr(wr[1]), .o_data(odat[1]),
        .o_last(olast[1]), .i_full(full[1]), .o_grant(grant[1]), .o_busy(busy[1])
`ifdef SFIFO_WR_ARBITER_STATS_EN
        , .o_pkt_count(pcnt[1]), .o_stall(stall[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic src_push(input int d, input int s, input logic [7:0] dat, input logic last);
        beat_t b;
        b.dat = dat;
        b.last = last;
        srcq[d][s].push_back(b);
    endtask

    task automatic exp_push(input int d, input int s, input logic [7:0] dat, input logic last);
        exp_t e;
        e.src = 2'(s);
        e.dat = dat;
        e.last = last;
        sbq[d].push_back(e);
    endtask

    // Main-process input changes land 2 time units after the rising edge
    task automatic at_drive();
        @(posedge clk);
        #2;
    endtask

    // Stop on the negedge where source s of dut d first presents valid
    task automatic wait_vld(input int d, input int s);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (v_vld[d][s]) seen = 1'b1;
        end
        if (!seen) fail_now("wait_valid_timeout");
    endtask

    task automatic wait_drain(input int d);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1;
            if (sbq[d].size() == 0 && !busy[d]) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
    endtask

    // Source models: accepted heads pop after the edge, next head is presented
    initial begin
        for (int d = 0; d < 2; d++) begin
            v_vld[d] = '0;
            v_dat[d] = '0;
            v_last[d] = '0;
            acc[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) acc[d] = v_vld[d] & rdy[d];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int s = 0; s < NIN; s++) begin
                    if (acc[d][s] && srcq[d][s].size() > 0) void'(srcq[d][s].pop_front());
                    if (srcq[d][s].size() > 0) begin
                        v_vld[d][s] = 1'b1;
                        v_dat[d][s*BW +: BW] = srcq[d][s][0].dat;
                        v_last[d][s] = srcq[d][s][0].last;
                    end else begin
                        v_vld[d][s] = 1'b0;
                        v_last[d][s] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every FIFO write is matched against the next expected beat
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wr[d]) begin
                wr_cnt[d]++;
                chk("wr_while_full", 32'(full[d]), 32'd0);
                chk("wr_not_busy", 32'(busy[d]), 32'd1);
                if (sbq[d].size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    mon_e = sbq[d].pop_front();
                    chk("wr_data", 32'(odat[d]), 32'(mon_e.dat));
                    chk("wr_last", 32'(olast[d]), 32'(mon_e.last));
                    chk("wr_src", 32'(grant[d]), 32'(4'b0001 << mon_e.src));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [NIN-1:0] rdy1_seen;
        n_checks = 0;
        n_pass = 0;
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
        full[0] = 1'b0;
        full[1] = 1'b0;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_wr", 32'(wr[0]), 32'd0);
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        at_drive();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Single source: src2 sends A1 A2 A3
        at_drive();
        src_push(0, 2, 8'hA1, 1'b0); exp_push(0, 2, 8'hA1, 1'b0);
        src_push(0, 2, 8'hA2, 1'b0); exp_push(0, 2, 8'hA2, 1'b0);
        src_push(0, 2, 8'hA3, 1'b1); exp_push(0, 2, 8'hA3, 1'b1);
        wait_vld(0, 2);
        chk("t1_arb_grant", 32'(grant[0]), 32'd0);
        chk("t1_arb_wr", 32'(wr[0]), 32'd0);
        @(negedge clk);
        chk("t1_grant", 32'(grant[0]), 32'b0100);
        chk("t1_wr0", 32'(wr[0]), 32'd1);
        @(negedge clk);
        chk("t1_wr1", 32'(wr[0]), 32'd1);
        @(negedge clk);
        chk("t1_wr2", 32'(wr[0]), 32'd1);
        chk("t1_last", 32'(olast[0]), 32'd1);
        @(negedge clk);
        chk("t1_idle", 32'(busy[0]), 32'd0);
        wait_drain(0);

        // Fairness: pointer back to 0, all sources with two 1-beat packets
        at_drive();
        rst_n[0] = 1'b0;
        at_drive();
        rst_n[0] = 1'b1;
        for (int s = 0; s < NIN; s++) src_push(0, s, 8'(8'h10 + s), 1'b1);
        for (int s = 0; s < NIN; s++) src_push(0, s, 8'(8'h20 + s), 1'b1);
        for (int s = 0; s < NIN; s++) exp_push(0, s, 8'(8'h10 + s), 1'b1);
        for (int s = 0; s < NIN; s++) exp_push(0, s, 8'(8'h20 + s), 1'b1);
        wait_vld(0, 0);
        #1;
        w0 = wr_cnt[0];
        repeat (16) @(negedge clk);
        #1;
        chk("t2_8pkts_16cyc", 32'(wr_cnt[0] - w0), 32'd8);
        wait_drain(0);

        // Packet lock: src0 4 beats, src1 waiting
        at_drive();
        for (int i = 0; i < 4; i++) begin
            src_push(0, 0, 8'(8'hB0 + i), (i == 3));
            exp_push(0, 0, 8'(8'hB0 + i), (i == 3));
        end
        src_push(0, 1, 8'hC0, 1'b1);
        exp_push(0, 1, 8'hC0, 1'b1);
        wait_vld(0, 0);
        rdy1_seen = rdy[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_contig_wr", 32'(wr[0]), 32'd1);
            rdy1_seen = rdy1_seen | rdy[0];
        end
        @(negedge clk);
        chk("t3_bubble_wr", 32'(wr[0]), 32'd0);
        rdy1_seen = rdy1_seen | rdy[0];
        chk("t3_src1_ready_held", 32'(rdy1_seen[1]), 32'd0);
        @(negedge clk);
        chk("t3_src1_grant", 32'(grant[0]), 32'b0010);
        chk("t3_src1_wr", 32'(wr[0]), 32'd1);
        wait_drain(0);

        // Backpressure: full for 3 cycles after 2 of 4 beats
        at_drive();
        for (int i = 0; i < 4; i++) begin
            src_push(0, 2, 8'(8'hD0 + i), (i == 3));
            exp_push(0, 2, 8'(8'hD0 + i), (i == 3));
        end
        wait_vld(0, 2);
        @(negedge clk);
        chk("t4_grant", 32'(grant[0]), 32'b0100);
        @(negedge clk);
        at_drive();
        full[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_full_wr", 32'(wr[0]), 32'd0);
            chk("t4_full_ready", 32'(rdy[0]), 32'd0);
            chk("t4_full_grant", 32'(grant[0]), 32'b0100);
        end
        chk("t4_held_data", 32'(odat[0]), 32'hD2);
        at_drive();
        full[0] = 1'b0;
        @(negedge clk);
        chk("t4_resume_wr", 32'(wr[0]), 32'd1);
        wait_drain(0);

        // Reset mid-packet: src1 4 beats, reset after 2; pointer was 3
        at_drive();
        for (int i = 0; i < 4; i++) src_push(0, 1, 8'(8'hE0 + i), (i == 3));
        exp_push(0, 1, 8'hE0, 1'b0);
        exp_push(0, 1, 8'hE1, 1'b0);
        wait_vld(0, 1);
        @(negedge clk);
        chk("t5_grant", 32'(grant[0]), 32'b0010);
        @(negedge clk);
        at_drive();
        rst_n[0] = 1'b0;
        srcq[0][1].delete();
        src_push(0, 0, 8'hF0, 1'b1); exp_push(0, 0, 8'hF0, 1'b1);
        src_push(0, 3, 8'h30, 1'b1); exp_push(0, 3, 8'h30, 1'b1);
        at_drive();
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("t5_rst_grant", 32'(grant[0]), 32'd0);
        chk("t5_rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        chk("t5_next_grant", 32'(grant[0]), 32'b0001);
        wait_drain(0);

        // Beat mode: src0 and src1 2-beat packets interleave per beat
        at_drive();
        src_push(1, 0, 8'h40, 1'b0);
        src_push(1, 0, 8'h41, 1'b1);
        src_push(1, 1, 8'h50, 1'b0);
        src_push(1, 1, 8'h51, 1'b1);
        exp_push(1, 0, 8'h40, 1'b0);
        exp_push(1, 1, 8'h50, 1'b0);
        exp_push(1, 0, 8'h41, 1'b1);
        exp_push(1, 1, 8'h51, 1'b1);
        wait_vld(1, 0);
`ifdef SFIFO_WR_ARBITER_STATS_EN
        chk("t6_stall_idle", 32'(stall[1]), 32'd0);
`endif
        at_drive();
        full[1] = 1'b1;
        @(negedge clk);
        chk("t6_full_busy", 32'(busy[1]), 32'd1);
        chk("t6_full_wr", 32'(wr[1]), 32'd0);
`ifdef SFIFO_WR_ARBITER_STATS_EN
        chk("t6_stall_on", 32'(stall[1]), 32'd1);
`endif
        at_drive();
        full[1] = 1'b0;
        @(negedge clk);
        chk("t6_resume_wr", 32'(wr[1]), 32'd1);
`ifdef SFIFO_WR_ARBITER_STATS_EN
        chk("t6_stall_off", 32'(stall[1]), 32'd0);
`endif
        wait_drain(1);
`ifdef SFIFO_WR_ARBITER_STATS_EN
        chk("t6_pkt_count", 32'(pcnt[1]), 32'd4);
`endif

        chk("left_expected_dut0", 32'(sbq[0].size()), 32'd0);
        chk("left_expected_dut1", 32'(sbq[1].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
